unidade_controle_jogadas: RTL and testbench

- Moore FSM that sequences the multi-round memory-game datapath (fluxo_dados).
- Round k (k = 0..15) requires the player to repeat ROM positions 0..k. The limit counter holds k; the address counter walks 0..k.
- Drives the clear, count and register enables of the datapath from the status flags it returns.
- Reports pronto, acertou, errou and timeout outcome, plus a state code for the 7-segment debug display.

---
 rtl/unidade_controle_jogadas.sv | 125 ++++++++++++
 tb/tb_unidade_controle_jogadas.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_jogadas.sv
// Moore control unit for the multi-round memory game: sequences the play register, address
// counter and limit counter of the datapath and reports the game outcome.
module unidade_controle_jogadas #(
    parameter bit TIMEOUT_EN = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada_feita,
    input  logic       chavesIgualMemoria,
    input  logic       enderecoIgualLimite,
    input  logic       fimL,
    input  logic       timeout,
    output logic       zeraR,
    output logic       registraR,
    output logic       zeraE,
    output logic       contaE,
    output logic       zeraL,
    output logic       contaL,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout_fim,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        StInicial       = 4'h0,
        StPreparacao    = 4'h1,
        StIniciaSeq     = 4'h2,
        StEspera        = 4'h3,
        StRegistra      = 4'h4,
        StCompara       = 4'h5,
        StProximo       = 4'h6,
        StFimSeq        = 4'h7,
        StProximaRodada = 4'h8,
        StFimAcerto     = 4'hA,
        StFimTimeout    = 4'hD,
        StFimErro       = 4'hE
    } state_e;

    state_e state_q, state_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StInicial;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StInicial:       if (iniciar) state_d = StPreparacao;
            StPreparacao:    state_d = StIniciaSeq;
            StIniciaSeq:     state_d = StEspera;
            StEspera: begin
                // A play arriving together with the timeout still counts.
                if (jogada_feita) begin
                    state_d = StRegistra;
                end else if (timeout && TIMEOUT_EN) begin
                    state_d = StFimTimeout;
                end
            end
            StRegistra:      state_d = StCompara;
            StCompara: begin
                if (!chavesIgualMemoria) begin
                    state_d = StFimErro;
                end else if (enderecoIgualLimite) begin
                    state_d = StFimSeq;
                end else begin
                    state_d = StProximo;
                end
            end
            StProximo:       state_d = StEspera;
            StFimSeq:        state_d = fimL ? StFimAcerto : StProximaRodada;
            StProximaRodada: state_d = StIniciaSeq;
            StFimAcerto, StFimErro, StFimTimeout: begin
                if (iniciar) state_d = StPreparacao;
            end
            default:         state_d = StInicial;
        endcase
    end

    always_comb begin
        zeraR       = 1'b0;
        registraR   = 1'b0;
        zeraE       = 1'b0;
        contaE      = 1'b0;
        zeraL       = 1'b0;
        contaL      = 1'b0;
        pronto      = 1'b0;
        acertou     = 1'b0;
        errou       = 1'b0;
        timeout_fim = 1'b0;
        db_estado   = state_q;
        case (state_q)
            StPreparacao: begin
                zeraR = 1'b1;
                zeraE = 1'b1;
                zeraL = 1'b1;
            end
            StIniciaSeq:     zeraE = 1'b1;
            StRegistra:      registraR = 1'b1;
            StProximo:       contaE = 1'b1;
            StProximaRodada: contaL = 1'b1;
            StFimAcerto: begin
                pronto  = 1'b1;
                acertou = 1'b1;
            end
            StFimErro: begin
                pronto = 1'b1;
                errou  = 1'b1;
            end
            StFimTimeout: begin
                pronto      = 1'b1;
                errou       = 1'b1;
                timeout_fim = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_unidade_controle_jogadas.sv
// Directed bench for unidade_controle_jogadas; a second instance with TIMEOUT_EN=0 shares inputs.
module tb_unidade_controle_jogadas;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0;
    logic       jogada_feita = 1'b0;
    logic       chavesIgualMemoria = 1'b0;
    logic       enderecoIgualLimite = 1'b0;
    logic       fimL = 1'b0;
    logic       timeout = 1'b0;

    logic       zeraR, registraR, zeraE, contaE, zeraL, contaL;
    logic       pronto, acertou, errou, timeout_fim;
    logic [3:0] db_estado;
    logic       zeraR2, registraR2, zeraE2, contaE2, zeraL2, contaL2;
    logic       pronto2, acertou2, errou2, timeout_fim2;
    logic [3:0] db_estado2;

    int compared = 0;
    int mismatched = 0;

    // Output vector order: zeraR registraR zeraE contaE zeraL contaL pronto acertou errou timeout_fim
    localparam logic [9:0] O_NONE = 10'b0000000000;
    localparam logic [9:0] O_ZR   = 10'b1000000000;
    localparam logic [9:0] O_RR   = 10'b0100000000;
    localparam logic [9:0] O_ZE   = 10'b0010000000;
    localparam logic [9:0] O_CE   = 10'b0001000000;
    localparam logic [9:0] O_ZL   = 10'b0000100000;
    localparam logic [9:0] O_CL   = 10'b0000010000;
    localparam logic [9:0] O_PR   = 10'b0000001000;
    localparam logic [9:0] O_AC   = 10'b0000000100;
    localparam logic [9:0] O_ER   = 10'b0000000010;
    localparam logic [9:0] O_TF   = 10'b0000000001;

    logic [9:0] outs, outs2;
    assign outs  = {zeraR, registraR, zeraE, contaE, zeraL, contaL,
                    pronto, acertou, errou, timeout_fim};
    assign outs2 = {zeraR2, registraR2, zeraE2, contaE2, zeraL2, contaL2,
                    pronto2, acertou2, errou2, timeout_fim2};

    unidade_controle_jogadas #(.TIMEOUT_EN(1'b1)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .jogada_feita(jogada_feita),
        .chavesIgualMemoria(chavesIgualMemoria), .enderecoIgualLimite(enderecoIgualLimite),
        .fimL(fimL), .timeout(timeout),
        .zeraR(zeraR), .registraR(registraR), .zeraE(zeraE), .contaE(contaE),
        .zeraL(zeraL), .contaL(contaL), .pronto(pronto), .acertou(acertou),
        .errou(errou), .timeout_fim(timeout_fim), .db_estado(db_estado)
    );

    unidade_controle_jogadas #(.TIMEOUT_EN(1'b0)) dut_noto (
        .clock(clock), .reset(reset), .iniciar(iniciar), .jogada_feita(jogada_feita),
        .chavesIgualMemoria(chavesIgualMemoria), .enderecoIgualLimite(enderecoIgualLimite),
        .fimL(fimL), .timeout(timeout),
        .zeraR(zeraR2), .registraR(registraR2), .zeraE(zeraE2), .contaE(contaE2),
        .zeraL(zeraL2), .contaL(contaL2), .pronto(pronto2), .acertou(acertou2),
        .errou(errou2), .timeout_fim(timeout_fim2), .db_estado(db_estado2)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] exp_st, input logic [9:0] exp_out);
        compared++;
        assert (db_estado === exp_st) else begin
            mismatched++;
            $error("FAIL %s state: got %h want %h", tag, db_estado, exp_st);
        end
        compared++;
        assert (outs === exp_out) else begin
            mismatched++;
            $error("FAIL %s outputs: got %b want %b", tag, outs, exp_out);
        end
    endtask

    task automatic chk2(input string tag, input logic [3:0] exp_st, input logic [9:0] exp_out);
        compared++;
        assert (db_estado2 === exp_st) else begin
            mismatched++;
            $error("FAIL %s state(noto): got %h want %h", tag, db_estado2, exp_st);
        end
        compared++;
        assert (outs2 === exp_out) else begin
            mismatched++;
            $error("FAIL %s outputs(noto): got %b want %b", tag, outs2, exp_out);
        end
    endtask

    initial begin
        // Reset held with iniciar high
        iniciar = 1'b1;
        tick();
        tick();
        chk("reset_hold", 4'h0, O_NONE);
        chk2("reset_hold", 4'h0, O_NONE);
        reset = 1'b1;
        tick();
        chk("prep", 4'h1, O_ZR | O_ZE | O_ZL);
        iniciar = 1'b0;
        tick();
        chk("inicia_seq", 4'h2, O_ZE);
        tick();
        chk("espera", 4'h3, O_NONE);
        tick();
        chk("espera_hold", 4'h3, O_NONE);

        // Round 0 correct, not final round
        jogada_feita = 1'b1; chavesIgualMemoria = 1'b1; enderecoIgualLimite = 1'b1; fimL = 1'b0;
        tick(); chk("r0_registra", 4'h4, O_RR);
        jogada_feita = 1'b0;
        tick(); chk("r0_compara", 4'h5, O_NONE);
        tick(); chk("r0_fim_seq", 4'h7, O_NONE);
        tick(); chk("r0_prox_rodada", 4'h8, O_CL);
        tick(); chk("r0_inicia_seq", 4'h2, O_ZE);
        tick(); chk("r0_espera", 4'h3, O_NONE);

        // Mid-round play
        jogada_feita = 1'b1; enderecoIgualLimite = 1'b0;
        tick(); chk("mid_registra", 4'h4, O_RR);
        jogada_feita = 1'b0;
        tick(); chk("mid_compara", 4'h5, O_NONE);
        tick(); chk("mid_proximo", 4'h6, O_CE);
        tick(); chk("mid_espera", 4'h3, O_NONE);

        // Play and timeout together: play wins; then final round won
        jogada_feita = 1'b1; timeout = 1'b1;
        tick(); chk("both_registra", 4'h4, O_RR);
        chk2("both_registra", 4'h4, O_RR);
        jogada_feita = 1'b0; timeout = 1'b0; enderecoIgualLimite = 1'b1; fimL = 1'b1;
        tick(); chk("win_compara", 4'h5, O_NONE);
        tick(); chk("win_fim_seq", 4'h7, O_NONE);
        tick(); chk("win_acerto", 4'hA, O_PR | O_AC);
        tick(); chk("win_hold", 4'hA, O_PR | O_AC);
        iniciar = 1'b1;
        tick(); chk("win_restart", 4'h1, O_ZR | O_ZE | O_ZL);
        iniciar = 1'b0; fimL = 1'b0;
        tick(); chk("rs_inicia_seq", 4'h2, O_ZE);
        tick(); chk("rs_espera", 4'h3, O_NONE);
        chk2("rs_espera", 4'h3, O_NONE);

        // Timeout in espera
        timeout = 1'b1;
        tick(); chk("to_fim", 4'hD, O_PR | O_ER | O_TF);
        chk2("to_ignored", 4'h3, O_NONE);
        timeout = 1'b0;
        tick(); chk("to_hold", 4'hD, O_PR | O_ER | O_TF);
        iniciar = 1'b1;
        tick(); chk("to_restart", 4'h1, O_ZR | O_ZE | O_ZL);
        chk2("to_iniciar_ignored", 4'h3, O_NONE);
        iniciar = 1'b0;
        tick(); chk("to_inicia_seq", 4'h2, O_ZE);
        tick(); chk("to_espera", 4'h3, O_NONE);

        // Wrong play
        jogada_feita = 1'b1; chavesIgualMemoria = 1'b0;
        tick(); chk("err_registra", 4'h4, O_RR);
        jogada_feita = 1'b0;
        tick(); chk("err_compara", 4'h5, O_NONE);
        tick(); chk("err_fim", 4'hE, O_PR | O_ER);
        chk2("err_fim", 4'hE, O_PR | O_ER);
        tick(); chk("err_hold", 4'hE, O_PR | O_ER);
        iniciar = 1'b1;
        tick(); chk("err_restart", 4'h1, O_ZR | O_ZE | O_ZL);
        iniciar = 1'b0;
        tick(); tick();
        chk("err_espera", 4'h3, O_NONE);

        // Win again, then asynchronous reset in fim_acerto
        jogada_feita = 1'b1; chavesIgualMemoria = 1'b1; fimL = 1'b1;
        tick();
        jogada_feita = 1'b0;
        tick(); tick(); tick();
        chk("win2_acerto", 4'hA, O_PR | O_AC);
        reset = 1'b0;
        #1;
        chk("async_reset", 4'h0, O_NONE);
        chk2("async_reset", 4'h0, O_NONE);
        tick();
        chk("reset_held", 4'h0, O_NONE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
